// File: rtl/rr_bus_mux_pkg.sv
// rr_bus_mux shared definitions.
// FSM state encoding and the channel-index width helper.
package rr_bus_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder.
// First set bit of req scanning ptr, ptr+1, ..., wrapping at M.
module rr_priority_pick
  import rr_bus_mux_pkg::*;
#(
  parameter int M = 4,
  localparam int CW = clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic          any,
  output logic [CW-1:0] idx
);

  logic [CW-1:0] j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = 0; k < M; k++) begin
      j = CW'((int'(ptr) + k) % M);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// Round-robin packet multiplexer, M channels of N bits.
// Grant locks for a whole packet; one output register stage.
module rr_bus_mux
  import rr_bus_mux_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4,
  localparam int CW = clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_last,
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic           out_last,
  output logic [CW-1:0]  out_chan,
  input  logic           out_ready
);

  state_t        state;
  logic [CW-1:0] grant;
  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_nxt;
  logic [CW-1:0] pick_idx;
  logic          pick_any;
  logic          load_en;
  logic          xfer;

  rr_priority_pick #(
    .M(M)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign load_en = !out_valid || out_ready;
  assign xfer    = (state == ST_LOCK)
                && in_valid[grant]
                && load_en;
  assign ptr_nxt = (grant == CW'(M - 1))
                 ? '0 : grant + 1'b1;

  // Never looks at in_valid, so no comb path input->ready.
  always_comb begin
    in_ready = '0;
    if (state == ST_LOCK)
      in_ready[grant] = load_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (xfer && in_last[grant]) begin
            ptr   <= ptr_nxt;
            state <= ST_IDLE;
          end
        end
      endcase
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*N +: N];
        out_last  <= in_last[grant];
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Bench for rr_bus_mux: directed M=4 runs plus random M=2/M=16
// runs, all checked each cycle against a behavioural model.
module tb_rr_bus_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_n;
  logic [2:0]        ordy;
  logic [2:0]        ov;
  logic [2:0]        ol;
  logic [2:0][15:0]  iv;
  logic [2:0][15:0]  il;
  logic [2:0][15:0]  ir;
  logic [2:0][511:0] idat;
  logic [2:0][31:0]  od;
  logic [2:0][3:0]   oc;

  for (genvar g = 0; g < 3; g++) begin : dut
    localparam int MM = (g == 0) ? 4 : (g == 1) ? 2 : 16;
    localparam int NN = (g == 0) ? 16 : (g == 1) ? 1 : 32;
    localparam int CC = $clog2(MM);
    logic [MM-1:0] rdy;
    logic [NN-1:0] d;
    logic [CC-1:0] ch;
    logic          v;
    logic          l;
    rr_bus_mux #(.N(NN), .M(MM)) u (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (iv[g][MM-1:0]),
      .in_data   (idat[g][MM*NN-1:0]),
      .in_last   (il[g][MM-1:0]),
      .in_ready  (rdy),
      .out_valid (v),
      .out_data  (d),
      .out_last  (l),
      .out_chan  (ch),
      .out_ready (ordy[g])
    );
    assign ir[g] = 16'(rdy);
    assign od[g] = 32'(d);
    assign oc[g] = 4'(ch);
    assign ov[g] = v;
    assign ol[g] = l;
  end

  int total = 0;
  int bad = 0;
  int mc[3] = '{4, 2, 16};
  int nc[3] = '{16, 1, 32};

  // model: per config, lock owner, scan start, output slot
  bit          armed[3];
  bit          m_lock[3];
  bit          m_ov[3];
  bit          m_l[3];
  int          m_g[3];
  int          m_ptr[3];
  int          m_c[3];
  logic [31:0] m_d[3];
  bit          sweep_on = 1'b0;
  int          drained[3];

  typedef struct {
    int          cfg;
    int          ch;
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t sb[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] msk(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] cdat(input int c, input int j);
    logic [31:0] v;
    v = idat[c][j*nc[c] +: 32];
    return v & msk(nc[c]);
  endfunction

  task automatic model_all();
    bit was;
    bit ld;
    bit found;
    int j;
    for (int c = 0; c < 3; c++) begin
      if (!rst_n[c]) begin
        armed[c] = 1'b1;
        m_lock[c] = 1'b0;
        m_ov[c] = 1'b0;
        m_l[c] = 1'b0;
        m_g[c] = 0;
        m_ptr[c] = 0;
        m_c[c] = 0;
        m_d[c] = '0;
      end else begin
        was = m_lock[c];
        ld = !m_ov[c] || ordy[c];
        if (was && iv[c][m_g[c]] && ld) begin
          m_ov[c] = 1'b1;
          m_d[c] = cdat(c, m_g[c]);
          m_l[c] = il[c][m_g[c]];
          m_c[c] = m_g[c];
          if (m_l[c]) begin
            m_lock[c] = 1'b0;
            m_ptr[c] = (m_g[c] + 1) % mc[c];
          end
        end else if (ordy[c]) begin
          m_ov[c] = 1'b0;
        end
        if (!was) begin
          found = 1'b0;
          for (int k = 0; k < mc[c]; k++) begin
            j = (m_ptr[c] + k) % mc[c];
            if (!found && iv[c][j]) begin
              found = 1'b1;
              m_g[c] = j;
            end
          end
          if (found) m_lock[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] er;
    int k;
    for (int c = 0; c < 3; c++) begin
      if (armed[c]) begin
        er = '0;
        if (m_lock[c] && (!m_ov[c] || ordy[c])) er[m_g[c]] = 1'b1;
        chk($sformatf("c%0d_in_ready", c), ir[c], er);
        chk($sformatf("c%0d_onehot", c), $countones(ir[c]) > 1, 0);
        chk($sformatf("c%0d_out_valid", c), ov[c], m_ov[c]);
        if (m_ov[c]) begin
          chk($sformatf("c%0d_out_data", c), od[c], m_d[c]);
          chk($sformatf("c%0d_out_last", c), ol[c], m_l[c]);
          chk($sformatf("c%0d_out_chan", c), oc[c], m_c[c]);
        end
        if (c > 0 && rst_n[c]) begin
          if (ov[c] && ordy[c]) begin
            k = -1;
            foreach (sb[i])
              if (k < 0 && sb[i].cfg == c && sb[i].ch == int'(oc[c]))
                k = i;
            if (k < 0) begin
              chk($sformatf("c%0d_sb_orphan", c), 1, 0);
            end else begin
              chk($sformatf("c%0d_sb_beat", c), {ol[c], od[c]},
                  {sb[k].l, sb[k].d});
              sb.delete(k);
              drained[c]++;
            end
          end
          for (int j = 0; j < mc[c]; j++)
            if (iv[c][j] && ir[c][j])
              sb.push_back('{c, j, cdat(c, j), il[c][j]});
        end
      end
    end
  endtask

  task automatic drive_rand();
    for (int c = 1; c < 3; c++) begin
      iv[c] = 16'($urandom) & 16'(msk(mc[c]));
      il[c] = 16'($urandom & $urandom & $urandom);
      for (int w = 0; w < 16; w++) idat[c][w*32 +: 32] = $urandom;
      ordy[c] = ($urandom_range(3) != 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_all();
    #1;
    if (sweep_on) drive_rand();
  endtask

  task automatic put(input int ch, input logic [15:0] v);
    idat[0][ch*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst_n[0] = 1'b0;
    iv[0] = '0;
    il[0] = '0;
    ordy[0] = 1'b1;
    cycle();
    rst_n[0] = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = '0;
    ordy = '1;
    iv = '0;
    il = '0;
    idat = '0;
    cycle();
    #1;
    chk("rst_ov", ov[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_last", ol[0], 0);
    chk("rst_chan", oc[0], 0);
    chk("rst_rdy", ir[0], 0);
    cycle();
    rst_n = '1;
    sweep_on = 1'b1;

    // 3-beat packet on channel 2
    do_reset();
    iv[0] = 16'b0100;
    put(2, 16'hA000);
    #1 chk("t1_c0_rdy", ir[0], 16'h0);
    cycle();
    #1 chk("t1_c1_rdy", ir[0], 16'b0100);
    chk("t1_c1_ov", ov[0], 0);
    cycle();
    put(2, 16'hA001);
    #1 chk("t1_c2_rdy", ir[0], 16'b0100);
    chk("t1_c2_ov", ov[0], 1);
    chk("t1_c2_data", od[0], 16'hA000);
    chk("t1_c2_chan", oc[0], 2);
    cycle();
    put(2, 16'hA002);
    il[0] = 16'b0100;
    #1 chk("t1_c3_rdy", ir[0], 16'b0100);
    chk("t1_c3_data", od[0], 16'hA001);
    chk("t1_c3_last", ol[0], 0);
    cycle();
    iv[0] = '0;
    il[0] = '0;
    #1 chk("t1_c4_rdy", ir[0], 16'h0);
    chk("t1_c4_data", od[0], 16'hA002);
    chk("t1_c4_last", ol[0], 1);
    chk("t1_model_ptr", m_ptr[0], 3);
    cycle();
    iv[0] = 16'b1001;
    il[0] = 16'b1001;
    put(3, 16'h3333);
    put(0, 16'h0000);
    #1 chk("t1_c5_ov", ov[0], 0);
    cycle();
    #1 chk("t1_ptr3_rdy", ir[0], 16'b1000);
    cycle();
    iv[0] = '0;
    il[0] = '0;
    #1 chk("t1_ptr3_chan", oc[0], 3);
    chk("t1_ptr3_data", od[0], 16'h3333);

    // all channels, single-beat packets back to back
    do_reset();
    iv[0] = 16'hF;
    il[0] = 16'hF;
    for (int i = 0; i < 4; i++) put(i, 16'hB000 + 16'(i));
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      chk("t2_ov", ov[0], (cyc >= 2 && cyc % 2 == 0));
      if (cyc >= 2 && cyc % 2 == 0) begin
        chk("t2_chan", oc[0], ((cyc - 2) / 2) % 4);
        chk("t2_data", od[0], 16'hB000 + ((cyc - 2) / 2) % 4);
      end
      cycle();
    end

    // back-pressure on channel 1 mid-packet
    do_reset();
    iv[0] = 16'b0010;
    put(1, 16'hC000);
    cycle();
    cycle();
    put(1, 16'hC001);
    ordy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_hold_data", od[0], 16'hC000);
      chk("t3_hold_rdy", ir[0], 16'h0);
      cycle();
    end
    ordy[0] = 1'b1;
    #1 chk("t3_rel_rdy", ir[0], 16'b0010);
    cycle();
    put(1, 16'hC002);
    il[0] = 16'b0010;
    #1 chk("t3_b1_data", od[0], 16'hC001);
    cycle();
    iv[0] = '0;
    il[0] = '0;
    #1 chk("t3_b2_data", od[0], 16'hC002);
    chk("t3_b2_last", ol[0], 1);

    // channel 3 stalls mid-packet, channel 0 must wait
    do_reset();
    iv[0] = 16'b1000;
    put(3, 16'hD000);
    cycle();
    cycle();
    iv[0] = 16'b0001;
    il[0] = 16'b0001;
    put(0, 16'hE000);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_stall_rdy", ir[0], 16'b1000);
      cycle();
    end
    iv[0] = 16'b1001;
    il[0] = 16'b1001;
    put(3, 16'hD001);
    #1 chk("t4_resume_rdy", ir[0], 16'b1000);
    cycle();
    iv[0] = 16'b0001;
    #1 chk("t4_d1_data", od[0], 16'hD001);
    chk("t4_d1_chan", oc[0], 3);
    chk("t4_idle_rdy", ir[0], 16'h0);
    cycle();
    #1 chk("t4_ch0_rdy", ir[0], 16'b0001);
    cycle();
    iv[0] = '0;
    il[0] = '0;
    #1 chk("t4_e0_data", od[0], 16'hE000);
    chk("t4_e0_chan", oc[0], 0);

    // reset in the middle of a channel 1 packet
    do_reset();
    iv[0] = 16'b0100;
    il[0] = 16'b0100;
    put(2, 16'h2222);
    cycle();
    cycle();
    iv[0] = 16'b0010;
    il[0] = '0;
    put(1, 16'hF000);
    cycle();
    cycle();
    put(1, 16'hF001);
    #1 chk("t5_f0_data", od[0], 16'hF000);
    rst_n[0] = 1'b0;
    cycle();
    rst_n[0] = 1'b1;
    iv[0] = 16'b1010;
    put(3, 16'h3333);
    #1 chk("t5_ov", ov[0], 0);
    chk("t5_rdy", ir[0], 16'h0);
    cycle();
    #1 chk("t5_regrant", ir[0], 16'b0010);
    iv[0] = '0;

    repeat (3000) cycle();
    sweep_on = 1'b0;
    iv[1] = '0;
    iv[2] = '0;
    ordy = '1;
    repeat (6) cycle();
    for (int c = 1; c < 3; c++) begin
      n = 0;
      foreach (sb[i]) if (sb[i].cfg == c) n++;
      chk($sformatf("c%0d_sb_left", c), n, 0);
      chk($sformatf("c%0d_sb_flow", c), drained[c] > 100, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_mux.md
# rr_bus_mux

Parametrised successor to the team's 4-channel, 16-bit bus multiplexer. Selects among M source channels under round-robin arbitration instead of an external SEL, and forwards whole packets with valid/ready handshakes. A grant is locked from a packet's first beat until its last beat. Output goes through one register stage onto the shared data bus; the block sits between peripheral sources and the single downstream bus consumer.

## Interface
- N, 16: data width per channel, ≥1
- M, 4: number of source channels, 2..16
- CW, $clog2(M): channel-index width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  M  per-channel beat valid
- in_data  input  M*N  channel i occupies bits [i*N +: N]
- in_last  input  M  per-channel last-beat-of-packet flag
- in_ready  output  M  per-channel accept; at most one bit high
- out_valid  output  1  output register holds a beat
- out_data  output  N  registered beat data
- out_last  output  1  registered last flag
- out_chan  output  CW  source channel of the registered beat
- out_ready  input  1  downstream accept

## Operation
- States: IDLE, LOCK. Registers: state, grant (CW), ptr (CW), and the output register (valid, data, last, chan).
- load_en = !out_valid || out_ready.
- IDLE:
  - If in_valid is nonzero, pick the first asserted channel scanning ptr, ptr+1, …, M-1, 0, …, ptr-1.
  - Register it into grant and go to LOCK.
  - No beat is accepted in IDLE; all in_ready = 0.
- LOCK:
  - in_ready[grant] = load_en; all other bits 0.
  - A transfer occurs when in_valid[grant] && in_ready[grant]. The output register then loads data, last, and chan = grant, and out_valid becomes 1.
  - A transfer with in_last[grant] = 1 sets ptr = (grant+1) mod M and returns to IDLE.
- Output side:
  - If out_valid && out_ready and no transfer occurs in the same cycle, out_valid becomes 0.
  - A simultaneous drain and load keeps out_valid = 1 with the new beat.
- Lock holds while the granted source drops in_valid mid-packet. No other channel is granted; the block waits indefinitely.
- Requests from non-granted channels never affect the output or the grant.
- ptr wraps from M-1 to 0. Channel i is always considered first only when ptr = i.
- A single-beat packet (first beat has last = 1) is legal: IDLE → LOCK → IDLE.
- in_data of non-granted channels is ignored.

## Timing
- Reset (rst_n low at a clk edge):
  - state = IDLE, grant = 0, ptr = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_chan = 0.
  - in_ready = 0 combinationally whenever state = IDLE.
- Reset mid-packet aborts the packet. The downstream consumer sees out_valid low from the next cycle. No partial state survives.
- Latency:
  - Request seen in IDLE at cycle 0 → grant registered at edge 1.
  - First beat accepted in cycle 1 (if load_en) → out_valid at edge 2.
- Throughput:
  - 1 beat/cycle within a packet while out_ready = 1.
  - Exactly one idle arbitration cycle between consecutive packets.
- in_ready depends combinationally on out_ready and registered state only. It never depends on in_valid.
- Output stability: while out_valid && !out_ready, out_data, out_last and out_chan are held unchanged.

## Structure
- Shared package/header rr_bus_mux_pkg:
  - state encoding constants ST_IDLE = 1'b0, ST_LOCK = 1'b1
  - a clog2 function for CW
- Sub-module rr_priority_pick:
  - purely combinational rotating-priority encoder, parameter M
  - inputs req[M], ptr[CW]; outputs any, idx[CW]
  - instantiated once; separately unit-testable
- Top holds the FSM, the output register and the M:1 data/last select (indexed part-select of the flattened bus).

## Test plan
- Reset, then channel 2 sends a 3-beat packet A0,A1,A2 (last on A2) with out_ready = 1:
  - in_ready[2] high for cycles 1–3
  - out_valid cycles 2–4, data A0..A2, out_chan = 2
  - ptr = 3 afterwards
- All 4 channels valid with single-beat packets continuously from reset: out_chan sequence 0,1,2,3,0,…, one beat every 2 cycles.
- Channel 1 mid-packet with out_ready held 0 for 5 cycles:
  - out_data frozen, in_ready[1] = 0
  - on release, beats resume in order with no loss or duplication
- Channel 3 locked, drops in_valid for 4 cycles while channel 0 asserts valid: no grant change, channel 0 waits until channel 3's last beat transfers.
- Assert rst_n = 0 for one cycle mid-packet on channel 1:
  - next cycle out_valid = 0, in_ready = 0, ptr = 0
  - a new request on channel 1 is granted from IDLE
- Parameter sweep, M = 2 with N = 1 and M = 16 with N = 32: random packets with random out_ready; per-channel packet order and beat integrity checked by a scoreboard; at most one in_ready bit high every cycle.
